// File: rtl/phys_reg_file.sv
// Physical register file: flop storage, per-preg ready bits,
// two writeback ports with read bypass, and rename-time busy marking.
module phys_reg_file #(
    parameter int NUM_PREGS = 64,
    parameter int XLEN      = 32,
    localparam int PW       = $clog2(NUM_PREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PW-1:0]   src1_reg_i,
    input  logic [PW-1:0]   src2_reg_i,
    output logic [XLEN-1:0] src1_val_o,
    output logic [XLEN-1:0] src2_val_o,
    output logic            src1_ready_o,
    output logic            src2_ready_o,
    input  logic            wb0_valid_i,
    input  logic [PW-1:0]   wb0_preg_i,
    input  logic [XLEN-1:0] wb0_data_i,
    input  logic            wb1_valid_i,
    input  logic [PW-1:0]   wb1_preg_i,
    input  logic [XLEN-1:0] wb1_data_i,
    input  logic            alloc_valid_i,
    input  logic [PW-1:0]   alloc_preg_i
);

    logic [XLEN-1:0]      data_q [NUM_PREGS];
    logic [XLEN-1:0]      data_d [NUM_PREGS];
    logic [NUM_PREGS-1:0] ready_q;
    logic [NUM_PREGS-1:0] ready_d;

    logic wb0_hit;
    logic wb1_hit;
    logic alloc_hit;

    // Preg 0 and out-of-range indices are hardwired zero/ready.
    function automatic logic live(input logic [PW-1:0] idx);
        return (idx != '0) && ({1'b0, idx} < (PW+1)'(NUM_PREGS));
    endfunction

    assign wb0_hit   = wb0_valid_i && live(wb0_preg_i);
    assign wb1_hit   = wb1_valid_i && live(wb1_preg_i);
    assign alloc_hit = alloc_valid_i && live(alloc_preg_i);

    // wb1 overrides wb0; alloc overrides either writeback's ready set.
    always_comb begin
        data_d  = data_q;
        ready_d = ready_q;
        if (wb0_hit) begin
            data_d[wb0_preg_i]  = wb0_data_i;
            ready_d[wb0_preg_i] = 1'b1;
        end
        if (wb1_hit) begin
            data_d[wb1_preg_i]  = wb1_data_i;
            ready_d[wb1_preg_i] = 1'b1;
        end
        if (alloc_hit) begin
            ready_d[alloc_preg_i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                data_q[i] <= '0;
            end
            ready_q <= '1;
        end else begin
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    logic [PW-1:0]   rd_idx [2];
    logic [XLEN-1:0] rd_val [2];
    logic            rd_rdy [2];

    assign rd_idx[0] = src1_reg_i;
    assign rd_idx[1] = src2_reg_i;

    for (genvar s = 0; s < 2; s++) begin : g_rd
        always_comb begin
            rd_val[s] = '0;
            rd_rdy[s] = 1'b1;
            if (live(rd_idx[s])) begin
                rd_val[s] = data_q[rd_idx[s]];
                rd_rdy[s] = ready_q[rd_idx[s]];
                if (wb0_hit && (wb0_preg_i == rd_idx[s])) begin
                    rd_val[s] = wb0_data_i;
                    rd_rdy[s] = 1'b1;
                end
                if (wb1_hit && (wb1_preg_i == rd_idx[s])) begin
                    rd_val[s] = wb1_data_i;
                    rd_rdy[s] = 1'b1;
                end
            end
        end
    end

    assign src1_val_o   = rd_val[0];
    assign src2_val_o   = rd_val[1];
    assign src1_ready_o = rd_rdy[0];
    assign src2_ready_o = rd_rdy[1];

endmodule

// File: tb/tb_phys_reg_file.sv
// Directed bench for phys_reg_file: reset, bypass, wb priority,
// alloc-vs-wb ordering, preg 0 and asynchronous mid-cycle reset.
module tb_phys_reg_file;

    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] src1_reg, src2_reg;
    logic [31:0]   src1_val, src2_val;
    logic          src1_ready, src2_ready;
    logic          wb0_valid, wb1_valid;
    logic [PW-1:0] wb0_preg, wb1_preg;
    logic [31:0]   wb0_data, wb1_data;
    logic          alloc_valid;
    logic [PW-1:0] alloc_preg;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    phys_reg_file #(.NUM_PREGS(64), .XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src1_reg_i   (src1_reg),
        .src2_reg_i   (src2_reg),
        .src1_val_o   (src1_val),
        .src2_val_o   (src2_val),
        .src1_ready_o (src1_ready),
        .src2_ready_o (src2_ready),
        .wb0_valid_i  (wb0_valid),
        .wb0_preg_i   (wb0_preg),
        .wb0_data_i   (wb0_data),
        .wb1_valid_i  (wb1_valid),
        .wb1_preg_i   (wb1_preg),
        .wb1_data_i   (wb1_data),
        .alloc_valid_i(alloc_valid),
        .alloc_preg_i (alloc_preg)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle();
        wb0_valid   = 1'b0;
        wb1_valid   = 1'b0;
        alloc_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        wb0_preg = '0; wb1_preg = '0; alloc_preg = '0;
        wb0_data = '0; wb1_data = '0;
        src1_reg = 6'd5;
        src2_reg = 6'd0;
        #12;
        chk("rst_v1", src1_val, 32'h0);
        chk("rst_r1", {31'b0, src1_ready}, 32'h1);
        chk("rst_v0", src2_val, 32'h0);
        chk("rst_r0", {31'b0, src2_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // alloc 7, then wb to 7 with bypass
        alloc_valid = 1'b1; alloc_preg = 6'd7;
        src1_reg = 6'd7;
        #1;
        chk("alloc_same_rdy", {31'b0, src1_ready}, 32'h1);
        tick();
        idle();
        #1;
        chk("alloc7_rdy", {31'b0, src1_ready}, 32'h0);
        wb0_valid = 1'b1; wb0_preg = 6'd7; wb0_data = 32'hDEADBEEF;
        #1;
        chk("byp7_v", src1_val, 32'hDEADBEEF);
        chk("byp7_r", {31'b0, src1_ready}, 32'h1);
        tick();
        idle();
        #1;
        chk("st7_v", src1_val, 32'hDEADBEEF);
        chk("st7_r", {31'b0, src1_ready}, 32'h1);

        // dual wb to same preg: wb1 wins
        wb0_valid = 1'b1; wb0_preg = 6'd9; wb0_data = 32'h11;
        wb1_valid = 1'b1; wb1_preg = 6'd9; wb1_data = 32'h22;
        src1_reg = 6'd9;
        #1;
        chk("byp9_v", src1_val, 32'h22);
        tick();
        idle();
        #1;
        chk("st9_v", src1_val, 32'h22);
        chk("st9_r", {31'b0, src1_ready}, 32'h1);

        // alloc and wb1 same preg: data stored, ready 0
        alloc_valid = 1'b1; alloc_preg = 6'd12;
        wb1_valid = 1'b1; wb1_preg = 6'd12; wb1_data = 32'h5;
        src1_reg = 6'd12;
        #1;
        chk("byp12_r", {31'b0, src1_ready}, 32'h1);
        tick();
        idle();
        #1;
        chk("st12_v", src1_val, 32'h5);
        chk("st12_r", {31'b0, src1_ready}, 32'h0);

        // preg 0 is immutable and never bypassed
        wb0_valid = 1'b1; wb0_preg = 6'd0; wb0_data = 32'hFFFFFFFF;
        alloc_valid = 1'b1; alloc_preg = 6'd0;
        src2_reg = 6'd0;
        #1;
        chk("p0_same_v", src2_val, 32'h0);
        chk("p0_same_r", {31'b0, src2_ready}, 32'h1);
        tick();
        idle();
        #1;
        chk("p0_next_v", src2_val, 32'h0);
        chk("p0_next_r", {31'b0, src2_ready}, 32'h1);

        // three unrelated events in one edge
        wb0_valid = 1'b1; wb0_preg = 6'd20; wb0_data = 32'h0000_0020;
        wb1_valid = 1'b1; wb1_preg = 6'd21; wb1_data = 32'h0000_0021;
        alloc_valid = 1'b1; alloc_preg = 6'd30;
        tick();
        idle();
        src1_reg = 6'd20; src2_reg = 6'd21;
        #1;
        chk("multi20", src1_val, 32'h20);
        chk("multi21", src2_val, 32'h21);
        src1_reg = 6'd30;
        #1;
        chk("multi30_r", {31'b0, src1_ready}, 32'h0);
        src2_reg = 6'd9;
        #1;
        chk("keep9", src2_val, 32'h22);

        // write 3, then async reset mid-cycle with pending wb/alloc
        wb0_valid = 1'b1; wb0_preg = 6'd3; wb0_data = 32'hA5A5A5A5;
        tick();
        idle();
        src1_reg = 6'd3; src2_reg = 6'd7;
        #1;
        chk("st3_v", src1_val, 32'hA5A5A5A5);
        wb1_valid = 1'b1; wb1_preg = 6'd40; wb1_data = 32'h77;
        alloc_valid = 1'b1; alloc_preg = 6'd41;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst3_v", src1_val, 32'h0);
        chk("arst3_r", {31'b0, src1_ready}, 32'h1);
        chk("arst7_v", src2_val, 32'h0);
        @(posedge clk);
        #1;
        idle();
        src1_reg = 6'd40; src2_reg = 6'd41;
        #1;
        chk("arst40_v", src1_val, 32'h0);
        chk("arst41_r", {31'b0, src2_ready}, 32'h1);

        // first edge after release performs normal writes/allocs
        @(negedge clk);
        rst_n = 1'b1;
        wb0_valid = 1'b1; wb0_preg = 6'd4; wb0_data = 32'h1234;
        alloc_valid = 1'b1; alloc_preg = 6'd5;
        tick();
        idle();
        src1_reg = 6'd4; src2_reg = 6'd5;
        #1;
        chk("post_v4", src1_val, 32'h1234);
        chk("post_r5", {31'b0, src2_ready}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
